// File: rtl/mod12_count_checker.sv
// Scoreboard for a modulo-N up/down counter: tracks the observed counter's
// inputs with a reference model and compares its output one cycle later.
module mod12_count_checker #(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chk_en,
  input  logic              mon_resetn,
  input  logic              mon_load,
  input  logic [3:0]        mon_din,
  input  logic              mon_up_down,
  input  logic [3:0]        mon_count,
  output logic [3:0]        exp_count,
  output logic              exp_valid,
  output logic              match,
  output logic              mismatch,
  output logic              din_err,
  output logic              err_sticky,
  output logic [STAT_W-1:0] chk_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic [3:0]        first_exp,
  output logic [3:0]        first_got
);

  localparam logic [0:0] UNSYNC = 1'b0;
  localparam logic [0:0] SYNC   = 1'b1;

  localparam logic [3:0]        CNT_MAX   = 4'(MODULUS - 1);
  localparam logic [4:0]        DIN_LIMIT = 5'(MODULUS);
  localparam logic [STAT_W-1:0] STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] model_nxt;
  logic       din_bad;
  logic       din_err_nxt;
  logic       do_cmp;
  logic       cmp_fail;

  // A counter reset in the same cycle outranks the load, so it masks din_err.
  always_comb begin
    din_bad     = mon_resetn && mon_load && ({1'b0, mon_din} >= DIN_LIMIT);
    din_err_nxt = (state == SYNC) && din_bad;
    do_cmp      = (state == SYNC) && chk_en;
    cmp_fail    = do_cmp && (exp_count != mon_count);
  end

  always_comb begin
    state_nxt = state;
    model_nxt = exp_count;
    case (state)
      UNSYNC: begin
        if (!mon_resetn) begin
          model_nxt = '0;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (!mon_resetn)
          model_nxt = '0;
        else if (mon_load)
          model_nxt = din_bad ? '0 : mon_din;
        else if (mon_up_down)
          model_nxt = (exp_count == CNT_MAX) ? '0 : exp_count + 4'd1;
        else
          model_nxt = (exp_count == '0) ? CNT_MAX : exp_count - 4'd1;
      end
      default: begin
        state_nxt = UNSYNC;
        model_nxt = '0;
      end
    endcase
  end

  assign exp_valid = (state == SYNC);

  // exp_count holds the prediction for mon_count in the current cycle, so
  // comparing it at this edge realises the one-cycle compare latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= UNSYNC;
      exp_count  <= '0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      din_err    <= 1'b0;
      err_sticky <= 1'b0;
      chk_cnt    <= '0;
      err_cnt    <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else begin
      state     <= state_nxt;
      exp_count <= model_nxt;
      match     <= do_cmp && !cmp_fail;
      mismatch  <= cmp_fail;
      din_err   <= din_err_nxt;
      if (cmp_fail || din_err_nxt)
        err_sticky <= 1'b1;
      if (do_cmp && (chk_cnt != '1))
        chk_cnt <= chk_cnt + STAT_ONE;
      if (cmp_fail && (err_cnt != '1))
        err_cnt <= err_cnt + STAT_ONE;
      if (cmp_fail && !err_sticky) begin
        first_exp <= exp_count;
        first_got <= mon_count;
      end
    end
  end

endmodule

// File: tb/tb_mod12_count_checker.sv
// Directed bench for mod12_count_checker; a second instance with 4-bit
// statistics shares the stimulus to exercise counter saturation.
module tb_mod12_count_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        chk_en;
  logic        mon_resetn;
  logic        mon_load;
  logic [3:0]  mon_din;
  logic        mon_up_down;
  logic [3:0]  mon_count;

  logic [3:0]  exp_count, first_exp, first_got;
  logic        exp_valid, match, mismatch, din_err, err_sticky;
  logic [15:0] chk_cnt, err_cnt;

  logic [3:0]  s_exp_count, s_first_exp, s_first_got;
  logic        s_exp_valid, s_match, s_mismatch, s_din_err, s_err_sticky;
  logic [3:0]  s_chk_cnt, s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mod12_count_checker dut (
    .clock(clock), .reset(reset), .chk_en(chk_en), .mon_resetn(mon_resetn),
    .mon_load(mon_load), .mon_din(mon_din), .mon_up_down(mon_up_down),
    .mon_count(mon_count), .exp_count(exp_count), .exp_valid(exp_valid),
    .match(match), .mismatch(mismatch), .din_err(din_err),
    .err_sticky(err_sticky), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_exp(first_exp), .first_got(first_got)
  );

  mod12_count_checker #(.MODULUS(12), .STAT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .chk_en(chk_en), .mon_resetn(mon_resetn),
    .mon_load(mon_load), .mon_din(mon_din), .mon_up_down(mon_up_down),
    .mon_count(mon_count), .exp_count(s_exp_count), .exp_valid(s_exp_valid),
    .match(s_match), .mismatch(s_mismatch), .din_err(s_din_err),
    .err_sticky(s_err_sticky), .chk_cnt(s_chk_cnt), .err_cnt(s_err_cnt),
    .first_exp(s_first_exp), .first_got(s_first_got)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  // cnt is the observed counter value presented during this cycle;
  // outputs are sampled 1 time unit after the edge.
  task automatic step(input logic rn, input logic ld, input logic [3:0] din,
                      input logic ud, input logic [3:0] cnt);
    mon_resetn  = rn;
    mon_load    = ld;
    mon_din     = din;
    mon_up_down = ud;
    mon_count   = cnt;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic m, input logic mm);
    chk({tag, "_match"}, 32'(match), 32'(m));
    chk({tag, "_mismatch"}, 32'(mismatch), 32'(mm));
  endtask

  initial begin
    reset = 1'b1; chk_en = 1'b1;
    mon_resetn = 1'b1; mon_load = 1'b0; mon_din = 4'd0;
    mon_up_down = 1'b1; mon_count = 4'd0;
    @(posedge clock); @(posedge clock); #1;

    chk("rst_exp_count", 32'(exp_count), 0);
    chk("rst_exp_valid", 32'(exp_valid), 0);
    chk_pulses("rst", 1'b0, 1'b0);
    chk("rst_din_err", 32'(din_err), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_chk_cnt", 32'(chk_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_first", {first_exp, first_got}, 0);
    reset = 1'b0;

    // Unsynchronised: toggling mon_count must not produce any compare.
    step(1, 0, 0, 1, 4'd5);  chk_pulses("unsync0", 1'b0, 1'b0);
    step(1, 0, 0, 1, 4'd3);  chk_pulses("unsync1", 1'b0, 1'b0);
    step(1, 0, 0, 0, 4'd9);  chk_pulses("unsync2", 1'b0, 1'b0);
    chk("unsync_valid", 32'(exp_valid), 0);
    chk("unsync_chk_cnt", 32'(chk_cnt), 0);

    // Sync, then 13 up-counts with a correct counter.
    step(0, 0, 0, 1, 4'd7);
    chk("sync_valid", 32'(exp_valid), 1);
    chk("sync_exp", 32'(exp_count), 0);
    chk_pulses("sync", 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      step(1, 0, 0, 1, 4'((i - 1) % 12));
      chk("up_exp", 32'(exp_count), 32'(i % 12));
      chk_pulses("up", 1'b1, 1'b0);
    end
    chk("up_chk_cnt", 32'(chk_cnt), 13);
    chk("up_err_cnt", 32'(err_cnt), 0);

    // Load 2 then count down through the wrap.
    step(1, 1, 4'd2, 1, 4'd1);  chk("ld_exp", 32'(exp_count), 2);   chk_pulses("ld", 1'b1, 1'b0);
    step(1, 0, 0, 0, 4'd2);     chk("dn1_exp", 32'(exp_count), 1);  chk_pulses("dn1", 1'b1, 1'b0);
    step(1, 0, 0, 0, 4'd1);     chk("dn2_exp", 32'(exp_count), 0);  chk_pulses("dn2", 1'b1, 1'b0);
    step(1, 0, 0, 0, 4'd0);     chk("dn3_exp", 32'(exp_count), 11); chk_pulses("dn3", 1'b1, 1'b0);
    step(1, 0, 0, 0, 4'd11);    chk("dn4_exp", 32'(exp_count), 10); chk_pulses("dn4", 1'b1, 1'b0);
    chk("dn_chk_cnt", 32'(chk_cnt), 18);

    // Fault: model predicts 4, counter shows 5.
    step(1, 1, 4'd4, 1, 4'd10); chk("ld4_exp", 32'(exp_count), 4);
    step(1, 0, 0, 1, 4'd5);
    chk_pulses("fault1", 1'b0, 1'b1);
    chk("fault1_exp", 32'(exp_count), 5);
    chk("fault1_err_cnt", 32'(err_cnt), 1);
    chk("fault1_sticky", 32'(err_sticky), 1);
    chk("fault1_first_exp", 32'(first_exp), 4);
    chk("fault1_first_got", 32'(first_got), 5);
    step(1, 0, 0, 1, 4'd5);     chk_pulses("fault_after", 1'b1, 1'b0);
    step(1, 0, 0, 1, 4'd9);     chk_pulses("fault2", 1'b0, 1'b1);
    chk("fault2_err_cnt", 32'(err_cnt), 2);
    chk("fault2_first_exp", 32'(first_exp), 4);
    chk("fault2_first_got", 32'(first_got), 5);
    chk("fault2_chk_cnt", 32'(chk_cnt), 22);

    // chk_en low: no compares, but the model keeps tracking.
    chk_en = 1'b0;
    step(1, 0, 0, 1, 4'd3);     chk_pulses("gate0", 1'b0, 1'b0); chk("gate0_exp", 32'(exp_count), 8);
    step(1, 0, 0, 1, 4'd0);     chk_pulses("gate1", 1'b0, 1'b0); chk("gate1_exp", 32'(exp_count), 9);
    chk("gate_chk_cnt", 32'(chk_cnt), 22);
    chk("gate_err_cnt", 32'(err_cnt), 2);
    chk_en = 1'b1;
    step(1, 0, 0, 1, 4'd9);     chk_pulses("regate", 1'b1, 1'b0); chk("regate_exp", 32'(exp_count), 10);

    // Reset on the edge where a mismatch result would be registered.
    reset = 1'b1;
    step(1, 0, 0, 1, 4'd5);
    chk_pulses("midrst", 1'b0, 1'b0);
    chk("midrst_valid", 32'(exp_valid), 0);
    chk("midrst_exp", 32'(exp_count), 0);
    chk("midrst_sticky", 32'(err_sticky), 0);
    chk("midrst_cnts", {chk_cnt, err_cnt}, 0);
    chk("midrst_first", {first_exp, first_got}, 0);
    chk("midrst_din_err", 32'(din_err), 0);
    chk("midrst_sat_cnts", {s_chk_cnt, s_err_cnt}, 0);
    reset = 1'b0;
    step(1, 0, 0, 1, 4'd0);
    chk("postrst_valid", 32'(exp_valid), 0);
    chk_pulses("postrst", 1'b0, 1'b0);
    step(0, 0, 0, 1, 4'd3);
    chk("resync_valid", 32'(exp_valid), 1);
    chk("resync_exp", 32'(exp_count), 0);

    // Illegal load value.
    step(1, 1, 4'd13, 1, 4'd0);
    chk("illegal_din_err", 32'(din_err), 1);
    chk("illegal_exp", 32'(exp_count), 0);
    chk("illegal_sticky", 32'(err_sticky), 1);
    chk("illegal_err_cnt", 32'(err_cnt), 0);
    chk_pulses("illegal", 1'b1, 1'b0);
    step(1, 0, 0, 1, 4'd0);
    chk("illegal_pulse_end", 32'(din_err), 0);
    chk("illegal_next_exp", 32'(exp_count), 1);
    step(0, 1, 4'd13, 1, 4'd1);
    chk("masked_din_err", 32'(din_err), 0);
    chk("masked_exp", 32'(exp_count), 0);

    // 20 mismatches: the 4-bit statistics saturate.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 1, 4'd15);
      chk_pulses("sat", 1'b0, 1'b1);
    end
    chk("sat_err_cnt", 32'(s_err_cnt), 15);
    chk("sat_chk_cnt", 32'(s_chk_cnt), 15);
    chk("wide_err_cnt", 32'(err_cnt), 20);
    chk("wide_chk_cnt", 32'(chk_cnt), 23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
